uart_alu_ctrl: RTL and testbench

Sequencer between the UART receiver/transmitter pair and the ALU datapath. Collects three consecutive received bytes (operand A, operand B, opcode) from `uart_rx`, holds them on the ALU inputs, and hands the ALU result to `uart_tx` as one byte. It then waits for transmit completion before accepting the next frame. It is the only block that drives the ALU inputs and `tx_start`.

---
 rtl/uart_alu_pkg.sv | 27 ++
 rtl/uart_alu_ctrl_gap_timer.sv | 35 +++
 rtl/uart_alu_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-to-ALU sequencer.
package uart_alu_pkg;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        EXEC    = ST_EXEC,
        WAIT_TX = ST_WAIT_TX
    } ctrl_state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_ctrl_gap_timer.sv
// Inter-byte gap counter; tc_o flags the last permitted idle cycle.
module ctrl_gap_timer #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frames A, B, opcode from the UART receiver into the ALU and sends the result back.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT           = 8,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_dout,
    input  logic            tx_done_tick,
    input  logic [DBIT-1:0] alu_result,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    output logic            busy,
    output logic            drop_tick,
    output logic            timeout_tick
);

    ctrl_state_t     state_q, state_d;
    logic [DBIT-1:0] a_q, a_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [DBIT-1:0] din_q, din_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            drop_q, drop_d;
    logic            tmo_q, tmo_d;
    logic            tmo_hit;
    logic            unused_rx_hi;

    assign unused_rx_hi = ^rx_dout[DBIT-1:OP_W];

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic gap_en;
    logic gap_clr;

    assign gap_en  = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign gap_clr = !gap_en || rx_done_tick;

    ctrl_gap_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_gap (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (gap_clr),
        .en_i  (gap_en),
        .tc_o  (tmo_hit)
    );
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        din_d   = din_q;
        start_d = 1'b0;
        drop_d  = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            WAIT_A: begin
                if (rx_done_tick) begin
                    a_d     = rx_dout;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done_tick) begin
                    b_d     = rx_dout;
                    state_d = WAIT_OP;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    op_d    = rx_dout[OP_W-1:0];
                    state_d = EXEC;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = WAIT_A;
                end
            end
            EXEC: begin
                din_d   = alu_result;
                start_d = 1'b1;
                drop_d  = rx_done_tick;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                drop_d = rx_done_tick;
                if (tx_done_tick) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            din_q   <= din_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign tx_din       = din_q;
    assign tx_start     = start_q;
    assign busy         = busy_q;
    assign drop_tick    = drop_q;
    assign timeout_tick = tmo_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a behavioural ALU on the result port.
module tb_uart_alu_ctrl;
    import uart_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = '0;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_din;
    logic [5:0] alu_op;
    logic       tx_start, busy, drop_tick, timeout_tick;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;
    int start_cnt = 0;
    int tmo_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
    } frame_t;

    frame_t vec[10];

    uart_alu_ctrl #(
        .DBIT           (8),
        .OP_W           (6),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .tx_done_tick (tx_done_tick),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .busy         (busy),
        .drop_tick    (drop_tick),
        .timeout_tick (timeout_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $signed(a) >>> b[2:0];
            OP_SRL:  return a >> b[2:0];
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    always @(negedge clk) begin
        if (drop_tick) drop_cnt++;
        if (tx_start) start_cnt++;
        if (timeout_tick) tmo_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dout = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_a"}, alu_a, 0);
        chk({nm, "_b"}, alu_b, 0);
        chk({nm, "_op"}, alu_op, 0);
        chk({nm, "_din"}, tx_din, 0);
        chk({nm, "_start"}, tx_start, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_drop"}, drop_tick, 0);
        chk({nm, "_tmo"}, timeout_tick, 0);
    endtask

    task automatic run_frame(input frame_t f);
        int s0;
        s0 = start_cnt;
        send_byte(f.a);
        chk("busy_rise", busy, 1);
        send_byte(f.b);
        send_byte(f.opb);
        chk("alu_a", alu_a, f.a);
        chk("alu_b", alu_b, f.b);
        chk("alu_op", alu_op, f.op);
        chk("start_early", tx_start, 0);
        tick();
        chk("tx_start", tx_start, 1);
        chk("tx_din", tx_din, f.res);
        tick();
        chk("start_width", tx_start, 0);
        chk("busy_tx", busy, 1);
        repeat (3) tick();
        pulse_tx_done();
        chk("busy_fall", busy, 0);
        chk("start_count", start_cnt - s0, 1);
    endtask

    initial begin
        int d0;
        int s0;
        vec[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vec[1] = '{8'hF0, 8'h0F, 8'h26, 6'h26, 8'hFF};
        vec[2] = '{8'h80, 8'h01, 8'h22, 6'h22, 8'h7F};
        vec[3] = '{8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08};
        vec[4] = '{8'h0C, 8'h0A, 8'h25, 6'h25, 8'h0E};
        vec[5] = '{8'h0C, 8'h0A, 8'h27, 6'h27, 8'hF1};
        vec[6] = '{8'hF0, 8'h02, 8'h03, 6'h03, 8'hFC};
        vec[7] = '{8'hF0, 8'h02, 8'h02, 6'h02, 8'h3C};
        vec[8] = '{8'h07, 8'h02, 8'hE0, 6'h20, 8'h09};
        vec[9] = '{8'h01, 8'h01, 8'h20, 6'h20, 8'h02};

        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // back-to-back frames, each starting right after tx_done_tick
        d0 = drop_cnt;
        for (int i = 0; i < 10; i++) begin
            run_frame(vec[i]);
        end
        chk("no_drop_seq", drop_cnt - d0, 0);

        // tx_done_tick in WAIT_A is ignored
        s0 = start_cnt;
        pulse_tx_done();
        tick();
        chk("idle_done_busy", busy, 0);
        chk("idle_done_a", alu_a, 8'h01);

        // tx_done_tick in WAIT_B is ignored, frame still completes
        send_byte(8'h09);
        pulse_tx_done();
        chk("wb_done_busy", busy, 1);
        send_byte(8'h04);
        send_byte(8'h20);
        chk("wb_done_op", alu_op, 6'h20);
        tick();
        chk("wb_done_din", tx_din, 8'h0D);
        chk("wb_done_starts", start_cnt - s0, 0);
        pulse_tx_done();

        // bytes during WAIT_TX are dropped, including one on tx_done_tick
        d0 = drop_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h20);
        tick();
        chk("drop_tx_din", tx_din, 8'h46);
        send_byte(8'hAA);
        chk("drop_pulse", drop_tick, 1);
        tick();
        chk("drop_width", drop_tick, 0);
        rx_dout = 8'hAA;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        chk("drop_coinc_busy", busy, 0);
        tick();
        chk("drop_count", drop_cnt - d0, 2);
        chk("drop_keep_a", alu_a, 8'h12);
        chk("drop_keep_b", alu_b, 8'h34);
        chk("drop_keep_op", alu_op, 6'h20);
        run_frame('{8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF});

        // reset mid-frame
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst_mid");
        reset = 1'b1;
        tick();
        run_frame('{8'h01, 8'h01, 8'h20, 6'h20, 8'h02});

        // reset mid-transmit; the late tx_done_tick must not disturb anything
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h20);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        pulse_tx_done();
        chk("rst_tx_busy", busy, 0);
        chk("rst_tx_din", tx_din, 0);
        run_frame('{8'h02, 8'h05, 8'h20, 6'h20, 8'h07});

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        send_byte(8'h33);
        repeat (99) tick();
        chk("tmo_pre_busy", busy, 1);
        chk("tmo_pre_tick", timeout_tick, 0);
        tick();
        chk("tmo_tick", timeout_tick, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_keep_a", alu_a, 8'h33);
        tick();
        chk("tmo_width", timeout_tick, 0);
        chk("tmo_count", tmo_cnt, 1);

        send_byte(8'h33);
        repeat (99) tick();
        send_byte(8'h44);
        chk("tc_accept_tmo", timeout_tick, 0);
        chk("tc_accept_busy", busy, 1);
        chk("tc_accept_b", alu_b, 8'h44);
        send_byte(8'h20);
        tick();
        chk("tc_accept_din", tx_din, 8'h77);
        pulse_tx_done();
        chk("tc_accept_count", tmo_cnt, 1);
`else
        send_byte(8'h33);
        repeat (150) tick();
        chk("no_tmo_busy", busy, 1);
        chk("no_tmo_count", tmo_cnt, 0);
        send_byte(8'h44);
        send_byte(8'h20);
        tick();
        chk("no_tmo_din", tx_din, 8'h77);
        pulse_tx_done();
        chk("no_tmo_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
